decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage, directly downstream of fetch. Accepts the registered 16-bit instruction, 8-bit PC and valid from fetch, and decodes fields. It reads a 16×16 register file and registers the ID/EX bundle. It also detects load-use hazards, resolves JMP and HALT, and returns stall, jump and halt controls to fetch.

## Interface
- No parameters. Widths are fixed: 16-bit instruction/data, 8-bit PC, 16 registers.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_instruction  in  16  instruction from fetch
- if_pc  in  8  PC of if_instruction
- if_valid  in  1  if_instruction is real
- ex_stall  in  1  execute cannot accept; hold ID/EX
- ex_flush  in  1  taken branch in execute; kill decode contents
- wb_en  in  1  register write enable
- wb_addr  in  4  register write address
- wb_data  in  16  register write data
- stall  out  1  to fetch stall input
- jump  out  1  to fetch PC_sel, one-cycle pulse
- jump_target  out  8  to fetch branch_target
- halt  out  1  sticky halt
- id_valid  out  1  ID/EX bundle valid
- id_pc  out  8  PC of bundle
- id_opcode  out  4  instr[15:12]
- id_rd  out  4  destination register
- id_rs1_data  out  16  operand A
- id_rs2_data  out  16  operand B / store data
- id_imm  out  16  immediate
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_illegal  out  1 each  control bits

## Operation
- Encoding: [15:12] op, [11:8] rd/ra, [7:4] rs1/rb, [3:0] rs2/imm4.
- Opcodes:
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR: rd ← rs1 op rs2.
  - 0110 ADDI: imm = sext(imm4).
  - 0111 LOAD: rd ← mem[rs1+sext(imm4)].
  - 1000 STORE: mem[rs1+sext(imm4)] ← reg[11:8].
  - 1001 BEQ / 1010 BNE: compare reg[11:8] with reg[7:4]; imm = sext(imm4); resolved in execute.
  - 1011 JMP: target = instr[11:4].
  - 1100 LI: rd ← zext(instr[7:0]).
  - 1101, 1110 illegal: id_illegal=1, all other controls 0.
  - 1111 HALT.
- Register file: 16×16. R0 reads 0; writes to R0 are ignored. Write at posedge when wb_en is set. A same-cycle read of wb_addr returns wb_data (write-through bypass).
- Working instruction: the replay buffer if it is full, else if_* .
- Load-use hazard: ID/EX is valid with id_mem_read=1, and its id_rd≠0 matches a source of the working instruction (rs1 for ALU/ADDI/LOAD/STORE; rs2 for R-type; [11:8] for STORE/BEQ/BNE). On a hazard, insert a bubble (id_valid←0) and hold the working instruction in the replay buffer.
- stall = hazard | ex_stall | halt | replay_full (combinational).
- Replay buffer: one entry. Capture a valid working instruction that cannot advance. Fetch drops valid while stalled and does not re-present the instruction, so decode replays it from the buffer. Clear the buffer when the instruction advances.
- JMP: when a valid JMP advances, register jump=1 and jump_target. Set squash, which discards the next valid if_* (the wrong-path PC+1), then clears. The JMP itself enters ID/EX as a NOP with id_valid=1.
- HALT: when a valid HALT advances, set halt=1 and keep it until reset. HALT enters ID/EX as a NOP. Afterwards all input is ignored and id_valid=0.
- Priority: reset > ex_flush > ex_stall > hazard > normal.
  - ex_flush clears id_valid, the replay buffer, squash and jump. halt is kept.
  - ex_stall holds every output register, the buffer and squash. jump is forced to 0.

## Timing
- Reset values: every output is 0, the buffer is empty, squash=0. The register file is not cleared.
- Latency: 1 cycle. if_* valid at edge N appears on id_* after edge N.
- A hazard costs exactly one bubble. The replayed instruction issues on the next edge.
- The jump pulse is 1 cycle wide and coincident with the JMP in ID/EX. Fetch redirects on the following edge.
- A reset asserted mid-stall or mid-squash takes effect at the next edge.

## Test plan
- Reset, then ADD R3,R1,R2 at PC 0x05 with R1=7 and R2=9 preloaded via wb. Next cycle: id_valid=1, id_pc=0x05, rs1_data=7, rs2_data=9, rd=3, reg_write=1.
- LOAD R4,[R1+2] followed by ADD R5,R4,R1. Expect one cycle with stall=1 and id_valid=0, then the ADD issues from replay with rs1 tag 4. No instruction is lost or duplicated.
- JMP 0x40 at PC 0x10. Expect jump=1 and jump_target=0x40 for one cycle; the instruction at 0x11 is squashed; the next id_pc is 0x40.
- HALT at PC 0x20. Expect halt=1 to stay sticky; stall=1; id_valid stays 0 for 10 further cycles; after reset, halt=0.
- ex_stall held 3 cycles with the ID/EX bundle valid. Expect all id_* unchanged. Then ex_flush: expect id_valid=0 and the replay buffer cleared.
- wb_en to R6=0xBEEF in the same cycle as a decode reading R6. Expect rs1_data=0xBEEF. A write to R0 with 0x1234 still reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: second pipeline stage, downstream of fetch.
// Decodes the fetched instruction, reads the 16x16 register file (with write-through
// bypass), and registers the ID/EX bundle. Also detects load-use hazards (one-entry
// replay buffer), resolves JMP (one-cycle jump pulse plus a squash of the wrong-path
// fetch) and HALT (sticky).
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   if_instruction/if_pc/if_valid   instruction from fetch
//   ex_stall, ex_flush          back-pressure and kill from execute
//   wb_en/wb_addr/wb_data       register file write port
//   stall, jump, jump_target, halt  controls returned to fetch
//   id_*                        registered ID/EX bundle
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] if_instruction,
  input  logic [7:0]  if_pc,
  input  logic        if_valid,
  input  logic        ex_stall,
  input  logic        ex_flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        jump,
  output logic [7:0]  jump_target,
  output logic        halt,
  output logic        id_valid,
  output logic [7:0]  id_pc,
  output logic [3:0]  id_opcode,
  output logic [3:0]  id_rd,
  output logic [15:0] id_rs1_data,
  output logic [15:0] id_rs2_data,
  output logic [15:0] id_imm,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_branch,
  output logic        id_illegal
);

  typedef enum logic [3:0] {
    OpNop, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi, OpLoad,
    OpStore, OpBeq, OpBne, OpJmp, OpLi, OpIll0, OpIll1, OpHalt
  } opcode_e;

  logic [15:0] rf_q [16];

  logic        id_valid_q, id_valid_d;
  logic [7:0]  id_pc_q, id_pc_d;
  logic [3:0]  id_opcode_q, id_opcode_d;
  logic [3:0]  id_rd_q, id_rd_d;
  logic [15:0] id_rs1_q, id_rs1_d, id_rs2_q, id_rs2_d, id_imm_q, id_imm_d;
  logic [4:0]  id_ctl_q, id_ctl_d;  // {reg_write, mem_read, mem_write, branch, illegal}
  logic        jump_q, jump_d, halt_q, halt_d, squash_q, squash_d;
  logic [7:0]  jump_target_q, jump_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [7:0]  buf_pc_q, buf_pc_d;

  logic [15:0] w_instr;
  logic [7:0]  w_pc;
  logic        w_valid, hazard;
  opcode_e     w_op;
  logic        is_rtype, is_store, is_branch, use_a, use_b, use_c;
  logic [3:0]  ra_a, ra_b;
  logic [15:0] rdata_a, rdata_b, sext4;
  logic [3:0]  dec_op, dec_rd;
  logic [15:0] dec_rs1, dec_rs2, dec_imm;
  logic [4:0]  dec_ctl;

  // Working instruction: replay buffer first; a squashed or post-halt fetch is not valid.
  always_comb begin
    w_instr  = buf_valid_q ? buf_instr_q : if_instruction;
    w_pc     = buf_valid_q ? buf_pc_q : if_pc;
    w_valid  = ~halt_q & (buf_valid_q | (if_valid & ~squash_q));
    w_op     = opcode_e'(w_instr[15:12]);
    is_rtype = (w_op == OpAdd) | (w_op == OpSub) | (w_op == OpAnd) | (w_op == OpOr) |
               (w_op == OpXor);
    is_store  = (w_op == OpStore);
    is_branch = (w_op == OpBeq) | (w_op == OpBne);
    use_a = is_rtype | (w_op == OpAddi) | (w_op == OpLoad) | is_store | is_branch;
    use_b = is_rtype;
    use_c = is_store | is_branch;
    hazard = w_valid & id_valid_q & id_ctl_q[3] & (id_rd_q != 4'd0) &
             ((use_a & (id_rd_q == w_instr[7:4])) |
              (use_b & (id_rd_q == w_instr[3:0])) |
              (use_c & (id_rd_q == w_instr[11:8])));
  end

  // Branches read ra as operand A and rb as operand B; stores send ra as store data.
  always_comb begin
    ra_a = is_branch ? w_instr[11:8] : w_instr[7:4];
    ra_b = is_store ? w_instr[11:8] : (is_branch ? w_instr[7:4] : w_instr[3:0]);
    rdata_a = rf_q[ra_a];
    if (wb_en && (wb_addr == ra_a)) rdata_a = wb_data;
    if (ra_a == 4'd0) rdata_a = '0;
    rdata_b = rf_q[ra_b];
    if (wb_en && (wb_addr == ra_b)) rdata_b = wb_data;
    if (ra_b == 4'd0) rdata_b = '0;
  end

  always_comb begin
    sext4   = {{12{w_instr[3]}}, w_instr[3:0]};
    dec_op  = w_instr[15:12];
    dec_rd  = '0;
    dec_rs1 = use_a ? rdata_a : '0;
    dec_rs2 = (use_b | use_c) ? rdata_b : '0;
    dec_imm = '0;
    dec_ctl = '0;
    case (w_op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        dec_rd = w_instr[11:8]; dec_ctl = 5'b10000;
      end
      OpAddi:  begin dec_rd = w_instr[11:8]; dec_imm = sext4; dec_ctl = 5'b10000; end
      OpLoad:  begin dec_rd = w_instr[11:8]; dec_imm = sext4; dec_ctl = 5'b11000; end
      OpStore: begin dec_imm = sext4; dec_ctl = 5'b00100; end
      OpBeq, OpBne: begin dec_imm = sext4; dec_ctl = 5'b00010; end
      OpLi: begin
        dec_rd = w_instr[11:8]; dec_imm = {8'h00, w_instr[7:0]}; dec_ctl = 5'b10000;
      end
      OpIll0, OpIll1: dec_ctl = 5'b00001;
      default: dec_op = 4'd0;  // NOP, JMP and HALT travel as NOPs
    endcase
  end

  always_comb begin
    id_valid_d = id_valid_q;  id_pc_d = id_pc_q;  id_opcode_d = id_opcode_q;
    id_rd_d = id_rd_q;  id_rs1_d = id_rs1_q;  id_rs2_d = id_rs2_q;
    id_imm_d = id_imm_q;  id_ctl_d = id_ctl_q;
    jump_d = 1'b0;  jump_target_d = jump_target_q;
    halt_d = halt_q;  squash_d = squash_q;
    buf_valid_d = buf_valid_q;  buf_instr_d = buf_instr_q;  buf_pc_d = buf_pc_q;
    if (ex_flush) begin
      id_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      squash_d    = 1'b0;
    end else if (ex_stall) begin
      // Fetch will not re-present this instruction, so keep it for later.
      if (w_valid && !buf_valid_q) begin
        buf_valid_d = 1'b1; buf_instr_d = w_instr; buf_pc_d = w_pc;
      end
    end else if (hazard) begin
      id_valid_d  = 1'b0;
      buf_valid_d = 1'b1; buf_instr_d = w_instr; buf_pc_d = w_pc;
    end else begin
      id_valid_d  = w_valid;
      buf_valid_d = 1'b0;
      if (squash_q && if_valid && !buf_valid_q) squash_d = 1'b0;
      if (w_valid) begin
        id_pc_d = w_pc;  id_opcode_d = dec_op;  id_rd_d = dec_rd;
        id_rs1_d = dec_rs1;  id_rs2_d = dec_rs2;  id_imm_d = dec_imm;  id_ctl_d = dec_ctl;
        if (w_op == OpJmp) begin
          jump_d = 1'b1; jump_target_d = w_instr[11:4]; squash_d = 1'b1;
        end
        if (w_op == OpHalt) halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;  id_pc_q <= '0;  id_opcode_q <= '0;  id_rd_q <= '0;
      id_rs1_q <= '0;  id_rs2_q <= '0;  id_imm_q <= '0;  id_ctl_q <= '0;
      jump_q <= 1'b0;  jump_target_q <= '0;  halt_q <= 1'b0;  squash_q <= 1'b0;
      buf_valid_q <= 1'b0;  buf_instr_q <= '0;  buf_pc_q <= '0;
    end else begin
      id_valid_q <= id_valid_d;  id_pc_q <= id_pc_d;  id_opcode_q <= id_opcode_d;
      id_rd_q <= id_rd_d;  id_rs1_q <= id_rs1_d;  id_rs2_q <= id_rs2_d;
      id_imm_q <= id_imm_d;  id_ctl_q <= id_ctl_d;
      jump_q <= jump_d;  jump_target_q <= jump_target_d;  halt_q <= halt_d;
      squash_q <= squash_d;
      buf_valid_q <= buf_valid_d;  buf_instr_q <= buf_instr_d;  buf_pc_q <= buf_pc_d;
    end
  end

  // Register file is deliberately not reset; R0 is never written.
  always_ff @(posedge clk) begin
    if (wb_en && (wb_addr != 4'd0)) rf_q[wb_addr] <= wb_data;
  end

  assign stall        = hazard | ex_stall | halt_q | buf_valid_q;
  assign jump         = jump_q;
  assign jump_target  = jump_target_q;
  assign halt         = halt_q;
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_opcode    = id_opcode_q;
  assign id_rd        = id_rd_q;
  assign id_rs1_data  = id_rs1_q;
  assign id_rs2_data  = id_rs2_q;
  assign id_imm       = id_imm_q;
  assign id_reg_write = id_ctl_q[4];
  assign id_mem_read  = id_ctl_q[3];
  assign id_mem_write = id_ctl_q[2];
  assign id_branch    = id_ctl_q[1];
  assign id_illegal   = id_ctl_q[0];

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] if_instruction = '0;
  logic [7:0]  if_pc = '0;
  logic        if_valid = 1'b0, ex_stall = 1'b0, ex_flush = 1'b0, wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        stall, jump, halt, id_valid;
  logic [7:0]  jump_target, id_pc;
  logic [3:0]  id_opcode, id_rd;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_illegal;

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [4:0]  ctl;
  } bundle_t;

  bundle_t     sb_q[$];
  logic [15:0] regs [16];
  int          n_vec = 0, n_err = 0;
  logic        held;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_instruction(if_instruction), .if_pc(if_pc),
    .if_valid(if_valid), .ex_stall(ex_stall), .ex_flush(ex_flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .jump(jump),
    .jump_target(jump_target), .halt(halt), .id_valid(id_valid), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_illegal(id_illegal)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set description and a shadow register file.
  function automatic bundle_t exp_of(input logic [7:0] pc, input logic [15:0] ins);
    bundle_t     e;
    logic [15:0] s4;
    s4 = {{12{ins[3]}}, ins[3:0]};
    e = '0;
    e.pc = pc;
    e.op = ins[15:12];
    case (ins[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        e.rd = ins[11:8]; e.a = regs[ins[7:4]]; e.b = regs[ins[3:0]]; e.ctl = 5'b10000;
      end
      4'h6: begin e.rd = ins[11:8]; e.a = regs[ins[7:4]]; e.imm = s4; e.ctl = 5'b10000; end
      4'h7: begin e.rd = ins[11:8]; e.a = regs[ins[7:4]]; e.imm = s4; e.ctl = 5'b11000; end
      4'h8: begin e.a = regs[ins[7:4]]; e.b = regs[ins[11:8]]; e.imm = s4; e.ctl = 5'b00100; end
      4'h9, 4'hA: begin
        e.a = regs[ins[11:8]]; e.b = regs[ins[7:4]]; e.imm = s4; e.ctl = 5'b00010;
      end
      4'hC: begin e.rd = ins[11:8]; e.imm = {8'h00, ins[7:0]}; e.ctl = 5'b10000; end
      4'hD, 4'hE: e.ctl = 5'b00001;
      default: e.op = 4'h0;
    endcase
    return e;
  endfunction

  // One clock; new bundles (not held by ex_stall) are popped and scored.
  task automatic tick();
    bundle_t cur, e;
    held = ex_stall;
    @(posedge clk);
    #1;
    if (id_valid && !held) begin
      cur = {id_pc, id_opcode, id_rd, id_rs1_data, id_rs2_data, id_imm,
             id_reg_write, id_mem_read, id_mem_write, id_branch, id_illegal};
      if (sb_q.size() == 0) check("unexpected_bundle", 96'(id_valid), 96'd0);
      else begin
        e = sb_q.pop_front();
        check("bundle", 96'(cur), 96'(e));
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (stall && n < 20) begin tick(); n++; end
    if (stall) check("ready_timeout", 96'(stall), 96'd0);
  endtask

  task automatic issue(input logic [7:0] pc, input logic [15:0] ins);
    wait_ready();
    if_pc = pc; if_instruction = ins; if_valid = 1'b1;
    sb_q.push_back(exp_of(pc, ins));
    tick();
    if_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    if (a != 4'd0) regs[a] = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    // Reset
    tick(); tick();
    check("rst_id_valid", 96'(id_valid), 96'd0);
    check("rst_halt", 96'(halt), 96'd0);
    check("rst_jump", 96'(jump), 96'd0);
    check("rst_stall", 96'(stall), 96'd0);
    check("rst_bundle", 96'({id_pc, id_opcode, id_rd, id_rs1_data, id_imm, jump_target}), 96'd0);
    reset = 1'b0;
    wb_write(4'd1, 16'd7);
    wb_write(4'd2, 16'd9);
    wb_write(4'd4, 16'h0044);

    // ADD R3,R1,R2 at 0x05
    issue(8'h05, 16'h1312);
    check("add_valid", 96'(id_valid), 96'd1);
    check("add_rs1", 96'(id_rs1_data), 96'd7);

    // LOAD R4,[R1+2] then dependent ADD R5,R4,R1
    issue(8'h06, 16'h7412);
    if_pc = 8'h07; if_instruction = 16'h1541; if_valid = 1'b1;
    sb_q.push_back(exp_of(8'h07, 16'h1541));
    #1;
    check("hazard_stall", 96'(stall), 96'd1);
    tick();
    if_valid = 1'b0;
    #1;
    check("bubble_valid", 96'(id_valid), 96'd0);
    check("bubble_stall", 96'(stall), 96'd1);
    tick();
    check("replay_valid", 96'(id_valid), 96'd1);
    check("replay_rs1", 96'(id_rs1_data), 96'h44);
    check("replay_stall", 96'(stall), 96'd0);

    // JMP 0x40 at 0x10; wrong-path 0x11 must be squashed
    wait_ready();
    if_pc = 8'h10; if_instruction = 16'hB400; if_valid = 1'b1;
    sb_q.push_back(exp_of(8'h10, 16'hB400));
    tick();
    check("jump_pulse", 96'(jump), 96'd1);
    check("jump_target", 96'(jump_target), 96'h40);
    if_pc = 8'h11; if_instruction = 16'h1312;
    tick();
    check("jump_fall", 96'(jump), 96'd0);
    check("squash_valid", 96'(id_valid), 96'd0);
    if_pc = 8'h40; if_instruction = 16'hC75A;
    sb_q.push_back(exp_of(8'h40, 16'hC75A));
    tick();
    if_valid = 1'b0;
    check("post_jump_pc", 96'(id_pc), 96'h40);

    // HALT at 0x20, then ten cycles of ignored input
    wait_ready();
    if_pc = 8'h20; if_instruction = 16'hF000; if_valid = 1'b1;
    sb_q.push_back(exp_of(8'h20, 16'hF000));
    tick();
    check("halt_set", 96'(halt), 96'd1);
    if_pc = 8'h21; if_instruction = 16'h1312;
    #1;
    check("halt_stall", 96'(stall), 96'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_idle", 96'(id_valid), 96'd0);
      check("halt_sticky", 96'(halt), 96'd1);
    end
    if_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_cleared", 96'(halt), 96'd0);
    check("halt_rst_stall", 96'(stall), 96'd0);

    // ex_stall for three cycles with a valid bundle, then ex_flush
    issue(8'h30, 16'h1312);
    ex_stall = 1'b1;
    if_pc = 8'h31; if_instruction = 16'h2312; if_valid = 1'b1;
    #1;
    check("exstall_stall", 96'(stall), 96'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if_valid = 1'b0;
      check("hold_bundle", 96'({id_valid, id_pc, id_opcode, id_rd, id_rs1_data, id_rs2_data}),
            96'({1'b1, 8'h30, 4'h1, 4'h3, 16'd7, 16'd9}));
      check("hold_jump", 96'(jump), 96'd0);
    end
    ex_stall = 1'b0; ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    #1;
    check("flush_valid", 96'(id_valid), 96'd0);
    check("flush_buf", 96'(stall), 96'd0);
    tick();
    check("flush_no_replay", 96'(id_valid), 96'd0);

    // Write-through bypass and R0 write suppression
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 16'hBEEF; regs[6] = 16'hBEEF;
    issue(8'h50, 16'h1861);
    check("bypass_rs1", 96'(id_rs1_data), 96'hBEEF);
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'h1234;
    issue(8'h51, 16'h1906);
    wb_en = 1'b0;
    check("r0_zero", 96'(id_rs1_data), 96'd0);
    tick();

    check("sb_drain", 96'(sb_q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
